// File: rtl/elink_pkg.sv
// Shared types and constants for the elink transmit path: packet layout,
// frame patterns, FSM state codes and the header byte packer.
package elink_pkg;

    localparam int ELINK_PKT_W = 103;

    localparam logic [7:0] FRAME_A = 8'h7F;
    localparam logic [7:0] FRAME_B = 8'hFF;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CYC_A = 2'd1;
    localparam logic [1:0] CYC_B = 2'd2;

    typedef struct packed {
        logic        write;
        logic [1:0]  datamode;
        logic [3:0]  ctrlmode;
        logic [31:0] dstaddr;
        logic [31:0] data;
        logic [31:0] srcaddr;
    } elink_pkt_t;

    function automatic logic [7:0] hdr_byte(input logic [3:0] ctrlmode,
                                            input logic [1:0] datamode,
                                            input logic       write);
        return {ctrlmode, datamode, write, 1'b1};
    endfunction

endpackage

// File: rtl/elink_tx_fifo.sv
// Synchronous FIFO, combinational read of the head; pop is ignored when empty.
// Backpressure: a push into a full FIFO is accepted only if a pop frees a slot the same edge.
module elink_tx_fifo #(
    parameter int WIDTH = 103,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_next_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == FULL_CNT);
    assign rd_data_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    assign count_next_o = count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/elink_tx_framer.sv
// Emesh-to-elink packetizer: each transaction becomes two 72-bit words; first word 2 edges after the access.
// Backpressure: emesh waits assert once the FIFO holds DEPTH-2; chip waits hold eligible heads in order.
module elink_tx_framer
    import elink_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic        txo_lclk,
    input  logic        reset,
    input  logic        emesh_access_outb,
    input  logic        emesh_write_outb,
    input  logic [1:0]  emesh_datamode_outb,
    input  logic [3:0]  emesh_ctrlmode_outb,
    input  logic [31:0] emesh_dstaddr_outb,
    input  logic [31:0] emesh_srcaddr_outb,
    input  logic [31:0] emesh_data_outb,
    input  logic        txo_wr_wait,
    input  logic        txo_rd_wait,
    output logic        emesh_wr_wait_inb,
    output logic        emesh_rd_wait_inb,
    output logic [71:0] tx_in,
    output logic        tx_overflow
);

    localparam logic [FIFO_AW:0] WAIT_THRESH = (FIFO_AW+1)'(FIFO_DEPTH - 2);

    logic [1:0]             wr_sync_q, rd_sync_q;
    logic                   wr_s, rd_s;
    elink_pkt_t             pkt_in, head_pkt;
    logic [ELINK_PKT_W-1:0] fifo_rd_data;
    logic                   fifo_full, fifo_empty, pop;
    logic [FIFO_AW:0]       count_next;
    logic                   head_ok;
    logic [1:0]             state_q, state_d;
    elink_pkt_t             hold_q, hold_d;
    logic [71:0]            tx_in_q, tx_in_d;
    logic                   wait_q, wait_d;
    logic                   overflow_q, overflow_d;

    always_ff @(posedge txo_lclk) begin
        if (reset) begin
            wr_sync_q <= '0;
            rd_sync_q <= '0;
        end else begin
            wr_sync_q <= {wr_sync_q[0], txo_wr_wait};
            rd_sync_q <= {rd_sync_q[0], txo_rd_wait};
        end
    end

    assign wr_s = wr_sync_q[1];
    assign rd_s = rd_sync_q[1];

    assign pkt_in = '{write:    emesh_write_outb,
                      datamode: emesh_datamode_outb,
                      ctrlmode: emesh_ctrlmode_outb,
                      dstaddr:  emesh_dstaddr_outb,
                      data:     emesh_data_outb,
                      srcaddr:  emesh_srcaddr_outb};

    elink_tx_fifo #(
        .WIDTH (ELINK_PKT_W),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk          (txo_lclk),
        .reset        (reset),
        .push_i       (emesh_access_outb),
        .pop_i        (pop),
        .wr_data_i    (pkt_in),
        .rd_data_o    (fifo_rd_data),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_next_o (count_next)
    );

    assign head_pkt = elink_pkt_t'(fifo_rd_data);
    // Strictly in order: only the head is ever considered, so a blocked head stalls everything behind it.
    assign head_ok  = !fifo_empty && (head_pkt.write ? !wr_s : !rd_s);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (head_ok) begin
                    pop     = 1'b1;
                    state_d = CYC_A;
                end
            end
            CYC_A: state_d = CYC_B;
            CYC_B: begin
                if (head_ok) begin
                    pop     = 1'b1;
                    state_d = CYC_A;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hold_d = pop ? head_pkt : hold_q;
        case (state_q)
            CYC_A:   tx_in_d = {FRAME_A, 8'h00,
                                hdr_byte(hold_q.ctrlmode, hold_q.datamode, hold_q.write),
                                hold_q.dstaddr, hold_q.data[31:16]};
            CYC_B:   tx_in_d = {FRAME_B, hold_q.data[15:0], hold_q.srcaddr, 16'h0000};
            default: tx_in_d = '0;
        endcase
        wait_d     = (count_next >= WAIT_THRESH);
        overflow_d = overflow_q | (emesh_access_outb && fifo_full && !pop);
    end

    always_ff @(posedge txo_lclk) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            tx_in_q    <= '0;
            wait_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            tx_in_q    <= tx_in_d;
            wait_q     <= wait_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_in             = tx_in_q;
    assign emesh_wr_wait_inb = wait_q;
    assign emesh_rd_wait_inb = wait_q;
    assign tx_overflow       = overflow_q;

endmodule

// File: tb/tb_elink_tx_framer.sv
// Directed plus random bench for elink_tx_framer; every non-idle tx_in word is
// also matched against a queue of words built from the byte-level frame layout.
module tb_elink_tx_framer;

    logic        txo_lclk = 1'b0;
    logic        reset = 1'b1;
    logic        emesh_access_outb = 1'b0;
    logic        emesh_write_outb = 1'b0;
    logic [1:0]  emesh_datamode_outb = '0;
    logic [3:0]  emesh_ctrlmode_outb = '0;
    logic [31:0] emesh_dstaddr_outb = '0;
    logic [31:0] emesh_srcaddr_outb = '0;
    logic [31:0] emesh_data_outb = '0;
    logic        txo_wr_wait = 1'b0;
    logic        txo_rd_wait = 1'b0;
    logic        emesh_wr_wait_inb;
    logic        emesh_rd_wait_inb;
    logic [71:0] tx_in;
    logic        tx_overflow;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [71:0] exp_q[$];

    elink_tx_framer #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .txo_lclk            (txo_lclk),
        .reset               (reset),
        .emesh_access_outb   (emesh_access_outb),
        .emesh_write_outb    (emesh_write_outb),
        .emesh_datamode_outb (emesh_datamode_outb),
        .emesh_ctrlmode_outb (emesh_ctrlmode_outb),
        .emesh_dstaddr_outb  (emesh_dstaddr_outb),
        .emesh_srcaddr_outb  (emesh_srcaddr_outb),
        .emesh_data_outb     (emesh_data_outb),
        .txo_wr_wait         (txo_wr_wait),
        .txo_rd_wait         (txo_rd_wait),
        .emesh_wr_wait_inb   (emesh_wr_wait_inb),
        .emesh_rd_wait_inb   (emesh_rd_wait_inb),
        .tx_in               (tx_in),
        .tx_overflow         (tx_overflow)
    );

    always #5 txo_lclk = ~txo_lclk;

    // Reference: lay out the 16 byte slots of a transaction, then pack 8 per word.
    function automatic logic [143:0] frame_words(input logic w, input logic [1:0] dm,
                                                 input logic [3:0] cm, input logic [31:0] dst,
                                                 input logic [31:0] dat, input logic [31:0] src);
        logic [7:0]  b [16];
        logic [71:0] wa, wb;
        b[0] = 8'h00;
        b[1] = {cm, dm, w, 1'b1};
        for (int i = 0; i < 4; i++) begin
            b[2+i]  = dst[31-8*i -: 8];
            b[10+i] = src[31-8*i -: 8];
        end
        b[6] = dat[31:24]; b[7] = dat[23:16]; b[8] = dat[15:8]; b[9] = dat[7:0];
        b[14] = 8'h00; b[15] = 8'h00;
        wa = '0; wb = '0;
        wa[71:64] = 8'b0111_1111;
        wb[71:64] = 8'b1111_1111;
        for (int i = 0; i < 8; i++) begin
            wa[63-8*i -: 8] = b[i];
            wb[63-8*i -: 8] = b[8+i];
        end
        return {wa, wb};
    endfunction

    task automatic tick();
        @(posedge txo_lclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input logic w, input logic [1:0] dm, input logic [3:0] cm,
                            input logic [31:0] dst, input logic [31:0] dat,
                            input logic [31:0] src, input bit accepted);
        logic [143:0] ww;
        emesh_access_outb   = 1'b1;
        emesh_write_outb    = w;
        emesh_datamode_outb = dm;
        emesh_ctrlmode_outb = cm;
        emesh_dstaddr_outb  = dst;
        emesh_data_outb     = dat;
        emesh_srcaddr_outb  = src;
        if (accepted) begin
            ww = frame_words(w, dm, cm, dst, dat, src);
            exp_q.push_back(ww[143:72]);
            exp_q.push_back(ww[71:0]);
        end
    endtask

    task automatic push_rand_write(input bit accepted);
        push_pkt(1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 $urandom(), $urandom(), $urandom(), accepted);
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) tick();
        check(tag, 72'(exp_q.size()), 72'd0);
    endtask

    // Scoreboard monitor: any non-idle word must be the next expected word.
    initial begin
        logic [71:0] exp_w;
        forever begin
            @(posedge txo_lclk);
            #3;
            if (tx_in !== 72'h0) begin
                n_assert++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL mon_extra: observed %h expected idle", tx_in);
                end
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    check("mon_word", tx_in, exp_w);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [143:0] ww;
        logic [71:0]  aw [8];
        logic [31:0]  d, s, a;
        int           sent;

        // Reset state
        tick(); tick();
        check("rst_tx_in", tx_in, 72'h0);
        check("rst_wr_wait", 72'(emesh_wr_wait_inb), 72'd0);
        check("rst_rd_wait", 72'(emesh_rd_wait_inb), 72'd0);
        check("rst_overflow", 72'(tx_overflow), 72'd0);
        exp_q.delete();
        reset = 1'b0;
        tick();

        // Single write, exact latency
        push_pkt(1'b1, 2'b10, 4'h0, 32'h8080_0010, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1);
        tick();
        emesh_access_outb = 1'b0;
        tick(); tick();
        check("single_a", tx_in, 72'h7F_00_0B_80_80_00_10_DE_AD);
        tick();
        check("single_b", tx_in, 72'hFF_BE_EF_00_00_12_34_00_00);
        tick();
        check("single_idle", tx_in, 72'h0);
        tick(); tick();

        // Four back-to-back writes
        for (int i = 0; i < 4; i++) begin
            a = $urandom(); d = $urandom(); s = $urandom();
            ww = frame_words(1'b1, 2'b10, 4'(i), a, d, s);
            aw[2*i] = ww[143:72];
            aw[2*i+1] = ww[71:0];
            push_pkt(1'b1, 2'b10, 4'(i), a, d, s, 1'b1);
            tick();
            if (i == 1) check("b2b_wait_low", 72'(emesh_wr_wait_inb), 72'd0);
            if (i == 2) begin
                check("b2b_wr_wait_high", 72'(emesh_wr_wait_inb), 72'd1);
                check("b2b_rd_wait_high", 72'(emesh_rd_wait_inb), 72'd1);
            end
            if (i >= 2) check("b2b_word", tx_in, aw[i-2]);
        end
        emesh_access_outb = 1'b0;
        for (int j = 4; j < 10; j++) begin
            tick();
            check("b2b_word", tx_in, aw[j-2]);
        end
        tick();
        check("b2b_idle", tx_in, 72'h0);
        check("b2b_overflow", 72'(tx_overflow), 72'd0);

        // Read head blocked by rd_wait, write queued behind it
        txo_rd_wait = 1'b1;
        tick(); tick(); tick();
        a = $urandom(); d = $urandom(); s = $urandom();
        ww = frame_words(1'b0, 2'b01, 4'h3, a, d, s);
        aw[0] = ww[143:72]; aw[1] = ww[71:0];
        push_pkt(1'b0, 2'b01, 4'h3, a, d, s, 1'b1);
        tick();
        a = $urandom(); d = $urandom(); s = $urandom();
        ww = frame_words(1'b1, 2'b10, 4'h5, a, d, s);
        aw[2] = ww[143:72]; aw[3] = ww[71:0];
        push_pkt(1'b1, 2'b10, 4'h5, a, d, s, 1'b1);
        tick();
        emesh_access_outb = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("rd_blocked", tx_in, 72'h0);
        end
        txo_rd_wait = 1'b0;
        tick(); tick(); tick();
        check("rd_release_gap", tx_in, 72'h0);
        for (int j = 0; j < 4; j++) begin
            tick();
            check("rd_release_word", tx_in, aw[j]);
        end
        tick();
        check("rd_release_idle", tx_in, 72'h0);

        // wr_wait arrives while the first packet is in flight
        a = $urandom(); d = $urandom(); s = $urandom();
        ww = frame_words(1'b1, 2'b00, 4'h1, a, d, s);
        aw[0] = ww[143:72]; aw[1] = ww[71:0];
        push_pkt(1'b1, 2'b00, 4'h1, a, d, s, 1'b1);
        tick();
        txo_wr_wait = 1'b1;
        a = $urandom(); d = $urandom(); s = $urandom();
        ww = frame_words(1'b1, 2'b11, 4'h2, a, d, s);
        aw[2] = ww[143:72]; aw[3] = ww[71:0];
        push_pkt(1'b1, 2'b11, 4'h2, a, d, s, 1'b1);
        tick();
        emesh_access_outb = 1'b0;
        tick();
        check("wrw_first_a", tx_in, aw[0]);
        tick();
        check("wrw_first_b", tx_in, aw[1]);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("wrw_held", tx_in, 72'h0);
        end
        txo_wr_wait = 1'b0;
        tick(); tick(); tick();
        check("wrw_release_gap", tx_in, 72'h0);
        tick();
        check("wrw_second_a", tx_in, aw[2]);
        tick();
        check("wrw_second_b", tx_in, aw[3]);
        tick();
        check("wrw_idle", tx_in, 72'h0);

        // Full FIFO: push on the same edge as the first pop must be accepted
        txo_wr_wait = 1'b1;
        tick(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            push_rand_write(1'b1);
            tick();
        end
        emesh_access_outb = 1'b0;
        check("fill_overflow", 72'(tx_overflow), 72'd0);
        txo_wr_wait = 1'b0;
        tick(); tick();
        push_rand_write(1'b1);
        tick();
        emesh_access_outb = 1'b0;
        check("pushpop_full_overflow", 72'(tx_overflow), 72'd0);
        drain("pushpop_drain");
        tick(); tick();

        // Overflow: fifth access into a full FIFO is dropped
        txo_wr_wait = 1'b1;
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            push_rand_write(i < 4);
            tick();
            if (i == 3) check("ovf_before", 72'(tx_overflow), 72'd0);
        end
        emesh_access_outb = 1'b0;
        check("ovf_set", 72'(tx_overflow), 72'd1);
        txo_wr_wait = 1'b0;
        drain("ovf_drain");
        repeat (6) tick();
        check("ovf_sticky", 72'(tx_overflow), 72'd1);
        check("ovf_no_fifth", tx_in, 72'h0);

        // Reset mid-packet
        for (int i = 0; i < 3; i++) begin
            push_rand_write(1'b1);
            tick();
        end
        emesh_access_outb = 1'b0;
        check("mid_wait_before", 72'(emesh_wr_wait_inb), 72'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_tx_in", tx_in, 72'h0);
        check("mid_rst_wr_wait", 72'(emesh_wr_wait_inb), 72'd0);
        check("mid_rst_rd_wait", 72'(emesh_rd_wait_inb), 72'd0);
        check("mid_rst_overflow", 72'(tx_overflow), 72'd0);
        exp_q.delete();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("mid_rst_empty", tx_in, 72'h0);
        end
        a = $urandom(); d = $urandom(); s = $urandom();
        ww = frame_words(1'b1, 2'b10, 4'h9, a, d, s);
        push_pkt(1'b1, 2'b10, 4'h9, a, d, s, 1'b1);
        tick();
        emesh_access_outb = 1'b0;
        tick(); tick();
        check("post_rst_a", tx_in, ww[143:72]);
        tick();
        check("post_rst_b", tx_in, ww[71:0]);
        tick();

        // Random traffic honouring the emesh waits, with wandering chip waits
        sent = 0;
        for (int g = 0; g < 3000 && sent < 40; g++) begin
            if ($urandom_range(0, 3) == 0) txo_wr_wait = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) txo_rd_wait = 1'($urandom_range(0, 1));
            if (!emesh_wr_wait_inb && $urandom_range(0, 2) != 0) begin
                push_pkt(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                         4'($urandom_range(0, 15)), $urandom(), $urandom(), $urandom(), 1'b1);
                sent++;
            end else begin
                emesh_access_outb = 1'b0;
            end
            tick();
        end
        emesh_access_outb = 1'b0;
        txo_wr_wait = 1'b0;
        txo_rd_wait = 1'b0;
        check("rand_sent", 72'(sent), 72'd40);
        drain("rand_drain");
        repeat (4) tick();
        check("rand_overflow", 72'(tx_overflow), 72'd0);
        check("rand_idle", tx_in, 72'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
